memory_game_ctrl: RTL

//   Game-state controller for the 4x4 card-matching board. It sits directly upstream of
//   the 16 per-card renderers and drives each renderer's face-up enable.
//   It tracks the cursor, flips cards on select, compares each pair of flipped cards and

---
 rtl/memory_game_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/memory_game_ctrl.sv
// Game-state controller for the 4x4 card-matching board: cursor, flips, pair compare,
// matched tracking and frame-counted hide of mismatched pairs. All outputs are registered.
module memory_game_ctrl #(
  parameter logic [47:0] LAYOUT      = 48'hFF6B_646D_2240,
  parameter int          HOLD_FRAMES = 60
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        frame_tick_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  input  logic        btn_sel_i,
  output logic [15:0] face_up_o,
  output logic [15:0] matched_o,
  output logic [3:0]  cursor_o,
  output logic [3:0]  pairs_o,
  output logic [7:0]  attempts_o,
  output logic        busy_o,
  output logic        win_o
);

  typedef enum logic [2:0] {S_IDLE, S_ONE, S_CHECK, S_SHOW, S_WIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] face_up_q, face_up_d;
  logic [15:0] matched_q, matched_d;
  logic [3:0]  cursor_q, cursor_d;
  logic [3:0]  pairs_q, pairs_d;
  logic [7:0]  attempts_q, attempts_d;
  logic [3:0]  first_q, first_d;
  logic [3:0]  second_q, second_d;
  logic [7:0]  hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        win_q, win_d;

  logic sel_ok, ids_eq;

  function automatic logic [2:0] pair_id(input logic [3:0] k);
    logic [5:0] idx;
    idx = {2'b00, k} + {1'b0, k, 1'b0};
    return LAYOUT[idx +: 3];
  endfunction

  assign sel_ok = btn_sel_i && !face_up_q[cursor_q];
  assign ids_eq = (pair_id(first_q) == pair_id(second_q));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      face_up_q  <= '0;
      matched_q  <= '0;
      cursor_q   <= '0;
      pairs_q    <= '0;
      attempts_q <= '0;
      first_q    <= '0;
      second_q   <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      face_up_q  <= face_up_d;
      matched_q  <= matched_d;
      cursor_q   <= cursor_d;
      pairs_q    <= pairs_d;
      attempts_q <= attempts_d;
      first_q    <= first_d;
      second_q   <= second_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      win_q      <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel_ok) state_d = S_ONE;
      S_ONE:   if (sel_ok) state_d = S_CHECK;
      S_CHECK: if (ids_eq) state_d = (pairs_q == 4'd7) ? S_WIN : S_IDLE;
               else        state_d = S_SHOW;
      S_SHOW:  if (frame_tick_i && hold_q == 8'd1) state_d = S_IDLE;
      S_WIN:   state_d = S_WIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    face_up_d  = face_up_q;
    matched_d  = matched_q;
    cursor_d   = cursor_q;
    pairs_d    = pairs_q;
    attempts_d = attempts_q;
    first_d    = first_q;
    second_d   = second_q;
    hold_d     = hold_q;
    case (state_q)
      S_IDLE, S_ONE: if (sel_ok) begin
        face_up_d[cursor_q] = 1'b1;
        if (state_q == S_IDLE) first_d  = cursor_q;
        else                   second_d = cursor_q;
      end
      S_CHECK: begin
        if (attempts_q != 8'hFF) attempts_d = attempts_q + 8'd1;
        if (ids_eq) begin
          matched_d[first_q]  = 1'b1;
          matched_d[second_q] = 1'b1;
          pairs_d             = pairs_q + 4'd1;
        end else begin
          hold_d = 8'(HOLD_FRAMES);
        end
      end
      S_SHOW: if (frame_tick_i) begin
        hold_d = hold_q - 8'd1;
        if (hold_q == 8'd1) begin
          face_up_d[first_q]  = 1'b0;
          face_up_d[second_q] = 1'b0;
        end
      end
      default: ;
    endcase
    // Select above used the pre-move cursor; one move per cycle, up > down > left > right.
    if (state_q != S_WIN) begin
      if      (btn_up_i)    cursor_d[3:2] = cursor_q[3:2] - 2'd1;
      else if (btn_down_i)  cursor_d[3:2] = cursor_q[3:2] + 2'd1;
      else if (btn_left_i)  cursor_d[1:0] = cursor_q[1:0] - 2'd1;
      else if (btn_right_i) cursor_d[1:0] = cursor_q[1:0] + 2'd1;
    end
    busy_d = (state_d == S_CHECK) || (state_d == S_SHOW);
    win_d  = (state_d == S_WIN);
  end

  assign face_up_o  = face_up_q;
  assign matched_o  = matched_q;
  assign cursor_o   = cursor_q;
  assign pairs_o    = pairs_q;
  assign attempts_o = attempts_q;
  assign busy_o     = busy_q;
  assign win_o      = win_q;

endmodule
